// File: rtl/ux607_jtagpinport_sync.sv
// ux607_jtagpinport_sync
// Conditions the JTAG pad inputs for the debug module. TCK/TMS/TDI (and
// TRST_n) are oversampled on the system clock, passed through a synchronizer
// chain and a per-channel stability filter. Filtered TCK edges are reported as
// one-cycle strobes. TDO and its enable are launched from a register that
// updates on the filtered TCK falling edge.
//
// Optional feature macro: UX607_JTAGPORT_TRST_EN
//   defined   : TRST_n pad is sampled and filtered; io_jtag_TRST = ~filtered TRST_n.
//   undefined : TRST_n pad is ignored and disabled; io_jtag_TRST comes from a
//               2-flop stretcher that holds TRST for 2 clocks after reset.
//
// Ports:
//   clock, reset                      system clock, async active-high reset
//   io_pins_<pad>_i_ival              pad input values (TDO unused)
//   io_pins_<pad>_o_{oval,oe,ie,pue,ds} pad controls
//   io_jtag_TCK/TMS/TDI               filtered JTAG inputs
//   io_jtag_TRST                      active-high TAP reset
//   io_jtag_TCK_rise/TCK_fall         one-cycle filtered TCK edge strobes
//   io_jtag_TDO, io_jtag_DRV_TDO      TDO data / enable from the TAP
module ux607_jtagpinport_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter bit          PULLUP_EN   = 1'b1
) (
  input  logic clock,
  input  logic reset,

  input  logic io_pins_TCK_i_ival,
  input  logic io_pins_TMS_i_ival,
  input  logic io_pins_TDI_i_ival,
  input  logic io_pins_TDO_i_ival,
  input  logic io_pins_TRST_n_i_ival,

  output logic io_pins_TCK_o_oval,
  output logic io_pins_TCK_o_oe,
  output logic io_pins_TCK_o_ie,
  output logic io_pins_TCK_o_pue,
  output logic io_pins_TCK_o_ds,
  output logic io_pins_TMS_o_oval,
  output logic io_pins_TMS_o_oe,
  output logic io_pins_TMS_o_ie,
  output logic io_pins_TMS_o_pue,
  output logic io_pins_TMS_o_ds,
  output logic io_pins_TDI_o_oval,
  output logic io_pins_TDI_o_oe,
  output logic io_pins_TDI_o_ie,
  output logic io_pins_TDI_o_pue,
  output logic io_pins_TDI_o_ds,
  output logic io_pins_TDO_o_oval,
  output logic io_pins_TDO_o_oe,
  output logic io_pins_TDO_o_ie,
  output logic io_pins_TDO_o_pue,
  output logic io_pins_TDO_o_ds,
  output logic io_pins_TRST_n_o_oval,
  output logic io_pins_TRST_n_o_oe,
  output logic io_pins_TRST_n_o_ie,
  output logic io_pins_TRST_n_o_pue,
  output logic io_pins_TRST_n_o_ds,

  output logic io_jtag_TCK,
  output logic io_jtag_TMS,
  output logic io_jtag_TDI,
  output logic io_jtag_TRST,
  output logic io_jtag_TCK_rise,
  output logic io_jtag_TCK_fall,
  input  logic io_jtag_TDO,
  input  logic io_jtag_DRV_TDO
);

`ifdef UX607_JTAGPORT_TRST_EN
  localparam int unsigned NCH = 4;
`else
  localparam int unsigned NCH = 3;
`endif
  localparam int unsigned CNT_W = 4;
  // Channel order: 0 TCK, 1 TMS, 2 TDI, 3 TRST_n. Idle-safe reset levels.
  localparam logic [3:0]       RST_VAL   = 4'b0110;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES);

  logic [NCH-1:0] w_pad_in;
  logic [NCH-1:0] w_filt;
  logic           w_unused;

  assign w_pad_in[0] = io_pins_TCK_i_ival;
  assign w_pad_in[1] = io_pins_TMS_i_ival;
  assign w_pad_in[2] = io_pins_TDI_i_ival;
`ifdef UX607_JTAGPORT_TRST_EN
  assign w_pad_in[3] = io_pins_TRST_n_i_ival;
  assign w_unused    = io_pins_TDO_i_ival;
`else
  assign w_unused    = io_pins_TDO_i_ival ^ io_pins_TRST_n_i_ival;
`endif

  // Per-channel synchronizer and stability filter.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_sync <= {SYNC_STAGES{RST_VAL[g]}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad_in[g]};
      end
    end

    // Any sample matching the filtered level restarts the stability count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_filt <= RST_VAL[g];
        r_cnt  <= '0;
      end else if (w_s == r_filt) begin
        r_cnt  <= '0;
      end else if ((r_cnt + CNT_W'(1)) == FILT_LAST) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end

    assign w_filt[g] = r_filt;
  end

  // TCK edge detection; the delayed copy resets to the filter reset level so
  // reset and its release never produce a strobe.
  logic r_tck_q;
  logic w_tck_rise;
  logic w_tck_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_tck_q <= 1'b0;
    else       r_tck_q <= w_filt[0];
  end

  assign w_tck_rise = w_filt[0] & ~r_tck_q;
  assign w_tck_fall = ~w_filt[0] & r_tck_q;

  // TDO launch on the filtered TCK falling edge.
  logic r_tdo_q;
  logic r_oe_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tdo_q <= 1'b0;
      r_oe_q  <= 1'b0;
    end else if (w_tck_fall) begin
      r_tdo_q <= io_jtag_TDO;
      r_oe_q  <= io_jtag_DRV_TDO;
    end
  end

`ifdef UX607_JTAGPORT_TRST_EN
  assign io_jtag_TRST          = ~w_filt[3];
  assign io_pins_TRST_n_o_ie   = 1'b1;
  assign io_pins_TRST_n_o_pue  = PULLUP_EN;
`else
  // Without a TRST pad, hold TAP reset for two clocks after system reset.
  logic [1:0] r_trst_stretch;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_trst_stretch <= 2'b11;
    else       r_trst_stretch <= {r_trst_stretch[0], 1'b0};
  end

  assign io_jtag_TRST          = r_trst_stretch[1];
  assign io_pins_TRST_n_o_ie   = 1'b0;
  assign io_pins_TRST_n_o_pue  = 1'b0;
`endif
  assign io_pins_TRST_n_o_oval = 1'b0;
  assign io_pins_TRST_n_o_oe   = 1'b0;
  assign io_pins_TRST_n_o_ds   = 1'b0;

  assign io_jtag_TCK      = w_filt[0];
  assign io_jtag_TMS      = w_filt[1];
  assign io_jtag_TDI      = w_filt[2];
  assign io_jtag_TCK_rise = w_tck_rise;
  assign io_jtag_TCK_fall = w_tck_fall;

  // Input-only pads.
  assign io_pins_TCK_o_oval = 1'b0;
  assign io_pins_TCK_o_oe   = 1'b0;
  assign io_pins_TCK_o_ie   = 1'b1;
  assign io_pins_TCK_o_pue  = PULLUP_EN;
  assign io_pins_TCK_o_ds   = 1'b0;
  assign io_pins_TMS_o_oval = 1'b0;
  assign io_pins_TMS_o_oe   = 1'b0;
  assign io_pins_TMS_o_ie   = 1'b1;
  assign io_pins_TMS_o_pue  = PULLUP_EN;
  assign io_pins_TMS_o_ds   = 1'b0;
  assign io_pins_TDI_o_oval = 1'b0;
  assign io_pins_TDI_o_oe   = 1'b0;
  assign io_pins_TDI_o_ie   = 1'b1;
  assign io_pins_TDI_o_pue  = PULLUP_EN;
  assign io_pins_TDI_o_ds   = 1'b0;

  // Output-only TDO pad.
  assign io_pins_TDO_o_oval = r_tdo_q;
  assign io_pins_TDO_o_oe   = r_oe_q;
  assign io_pins_TDO_o_ie   = 1'b0;
  assign io_pins_TDO_o_pue  = 1'b0;
  assign io_pins_TDO_o_ds   = 1'b0;

endmodule

// File: tb/tb_ux607_jtagpinport_sync.sv
// Testbench for ux607_jtagpinport_sync: default instance plus a
// SYNC_STAGES=3 / FILT_CYCLES=1 instance sharing the same pad stimulus.
module tb_ux607_jtagpinport_sync;

  logic clk;
  logic rst;
  logic tck, tms, tdi, tdo_pad, trstn, jtdo, jdrv;

  // Pad index: 0 TCK, 1 TMS, 2 TDI, 3 TDO, 4 TRST_n
  logic [4:0] p_oval, p_oe, p_ie, p_pue, p_ds;
  logic [4:0] q_oval, q_oe, q_ie, q_pue, q_ds;
  logic j_tck, j_tms, j_tdi, j_trst, j_rise, j_fall;
  logic k_tck, k_tms, k_tdi, k_trst, k_rise, k_fall;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ux607_jtagpinport_sync u_dut (
    .clock(clk), .reset(rst),
    .io_pins_TCK_i_ival(tck), .io_pins_TMS_i_ival(tms), .io_pins_TDI_i_ival(tdi),
    .io_pins_TDO_i_ival(tdo_pad), .io_pins_TRST_n_i_ival(trstn),
    .io_pins_TCK_o_oval(p_oval[0]), .io_pins_TCK_o_oe(p_oe[0]), .io_pins_TCK_o_ie(p_ie[0]),
    .io_pins_TCK_o_pue(p_pue[0]), .io_pins_TCK_o_ds(p_ds[0]),
    .io_pins_TMS_o_oval(p_oval[1]), .io_pins_TMS_o_oe(p_oe[1]), .io_pins_TMS_o_ie(p_ie[1]),
    .io_pins_TMS_o_pue(p_pue[1]), .io_pins_TMS_o_ds(p_ds[1]),
    .io_pins_TDI_o_oval(p_oval[2]), .io_pins_TDI_o_oe(p_oe[2]), .io_pins_TDI_o_ie(p_ie[2]),
    .io_pins_TDI_o_pue(p_pue[2]), .io_pins_TDI_o_ds(p_ds[2]),
    .io_pins_TDO_o_oval(p_oval[3]), .io_pins_TDO_o_oe(p_oe[3]), .io_pins_TDO_o_ie(p_ie[3]),
    .io_pins_TDO_o_pue(p_pue[3]), .io_pins_TDO_o_ds(p_ds[3]),
    .io_pins_TRST_n_o_oval(p_oval[4]), .io_pins_TRST_n_o_oe(p_oe[4]), .io_pins_TRST_n_o_ie(p_ie[4]),
    .io_pins_TRST_n_o_pue(p_pue[4]), .io_pins_TRST_n_o_ds(p_ds[4]),
    .io_jtag_TCK(j_tck), .io_jtag_TMS(j_tms), .io_jtag_TDI(j_tdi), .io_jtag_TRST(j_trst),
    .io_jtag_TCK_rise(j_rise), .io_jtag_TCK_fall(j_fall),
    .io_jtag_TDO(jtdo), .io_jtag_DRV_TDO(jdrv)
  );

  ux607_jtagpinport_sync #(.SYNC_STAGES(3), .FILT_CYCLES(1), .PULLUP_EN(1'b1)) u_dut2 (
    .clock(clk), .reset(rst),
    .io_pins_TCK_i_ival(tck), .io_pins_TMS_i_ival(tms), .io_pins_TDI_i_ival(tdi),
    .io_pins_TDO_i_ival(tdo_pad), .io_pins_TRST_n_i_ival(trstn),
    .io_pins_TCK_o_oval(q_oval[0]), .io_pins_TCK_o_oe(q_oe[0]), .io_pins_TCK_o_ie(q_ie[0]),
    .io_pins_TCK_o_pue(q_pue[0]), .io_pins_TCK_o_ds(q_ds[0]),
    .io_pins_TMS_o_oval(q_oval[1]), .io_pins_TMS_o_oe(q_oe[1]), .io_pins_TMS_o_ie(q_ie[1]),
    .io_pins_TMS_o_pue(q_pue[1]), .io_pins_TMS_o_ds(q_ds[1]),
    .io_pins_TDI_o_oval(q_oval[2]), .io_pins_TDI_o_oe(q_oe[2]), .io_pins_TDI_o_ie(q_ie[2]),
    .io_pins_TDI_o_pue(q_pue[2]), .io_pins_TDI_o_ds(q_ds[2]),
    .io_pins_TDO_o_oval(q_oval[3]), .io_pins_TDO_o_oe(q_oe[3]), .io_pins_TDO_o_ie(q_ie[3]),
    .io_pins_TDO_o_pue(q_pue[3]), .io_pins_TDO_o_ds(q_ds[3]),
    .io_pins_TRST_n_o_oval(q_oval[4]), .io_pins_TRST_n_o_oe(q_oe[4]), .io_pins_TRST_n_o_ie(q_ie[4]),
    .io_pins_TRST_n_o_pue(q_pue[4]), .io_pins_TRST_n_o_ds(q_ds[4]),
    .io_jtag_TCK(k_tck), .io_jtag_TMS(k_tms), .io_jtag_TDI(k_tdi), .io_jtag_TRST(k_trst),
    .io_jtag_TCK_rise(k_rise), .io_jtag_TCK_fall(k_fall),
    .io_jtag_TDO(jtdo), .io_jtag_DRV_TDO(jdrv)
  );

  typedef struct {
    logic tck, tms, tdi, tdo, drv;
    logic e_tck, e_tms, e_tdi, e_rise, e_fall, e_oval, e_oe, e_tms2;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vt [NVEC];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // in = {tck,tms,tdi,tdo,drv}; ex = {tck,tms,tdi,rise,fall,oval,oe,tms2}
  task automatic setv(input int i, input logic [4:0] in, input logic [7:0] ex);
    {vt[i].tck, vt[i].tms, vt[i].tdi, vt[i].tdo, vt[i].drv} = in;
    {vt[i].e_tck, vt[i].e_tms, vt[i].e_tdi, vt[i].e_rise, vt[i].e_fall,
     vt[i].e_oval, vt[i].e_oe, vt[i].e_tms2} = ex;
  endtask

  function automatic logic trst_exp(input int k, input int lat);
    return (k < lat) ? 1'b1 : 1'b0;
  endfunction

  int trst_lat;
  int trst_lat2;
  logic trst_ie_exp;

  initial begin
`ifdef UX607_JTAGPORT_TRST_EN
    trst_lat    = 5;
    trst_lat2   = 4;
    trst_ie_exp = 1'b1;
`else
    trst_lat    = 2;
    trst_lat2   = 2;
    trst_ie_exp = 1'b0;
`endif
    // TMS 1->0 at row 0; TCK 3-cycle pulse rows 0-2; TDI 2-cycle glitch rows 2-3;
    // TDO/DRV set from row 4; TDO toggled in low phase; TCK 2-cycle glitch rows 10-11.
    setv(0,  5'b10100, 8'b01100001);
    setv(1,  5'b10100, 8'b01100001);
    setv(2,  5'b10000, 8'b01100001);
    setv(3,  5'b00000, 8'b01100000);
    setv(4,  5'b00111, 8'b10110000);
    setv(5,  5'b00111, 8'b10100000);
    setv(6,  5'b00111, 8'b10100000);
    setv(7,  5'b00111, 8'b00101000);
    setv(8,  5'b00111, 8'b00100110);
    setv(9,  5'b00100, 8'b00100110);
    setv(10, 5'b10100, 8'b00100110);
    setv(11, 5'b10110, 8'b00100110);
    for (int i = 12; i < NVEC; i++) setv(i, 5'b00100, 8'b00100110);

    // Reset with idle pads
    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b1; trstn = 1'b1;
    tdo_pad = 1'b0; jtdo = 1'b0; jdrv = 1'b0;
    repeat (3) tick();
    chk("rst_tck", j_tck, 1'b0);
    chk("rst_tms", j_tms, 1'b1);
    chk("rst_tdi", j_tdi, 1'b1);
    chk("rst_trst", j_trst, 1'b1);
    chk("rst_tdo_oe", p_oe[3], 1'b0);
    chk("rst_tdo_oval", p_oval[3], 1'b0);
    chk("tck_pad_ie", p_ie[0], 1'b1);
    chk("tck_pad_pue", p_pue[0], 1'b1);
    chk("tck_pad_oe", p_oe[0], 1'b0);
    chk("tdo_pad_ie", p_ie[3], 1'b0);
    chk("trst_pad_ie", p_ie[4], trst_ie_exp);
    chk("trst_pad_pue", p_pue[4], trst_ie_exp);
    chk("trst_pad_oe", p_oe[4], 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_trst", j_trst, trst_exp(k, trst_lat));
      chk("rel_trst2", k_trst, trst_exp(k, trst_lat2));
      chk("rel_no_rise", j_rise, 1'b0);
      chk("rel_no_fall", j_fall, 1'b0);
    end

    // Table-driven: latency, glitch rejection, strobes, TDO launch
    for (int i = 0; i < NVEC; i++) begin
      tck = vt[i].tck; tms = vt[i].tms; tdi = vt[i].tdi;
      jtdo = vt[i].tdo; jdrv = vt[i].drv;
      tick();
      chk($sformatf("v%0d_tck", i),  j_tck,     vt[i].e_tck);
      chk($sformatf("v%0d_tms", i),  j_tms,     vt[i].e_tms);
      chk($sformatf("v%0d_tdi", i),  j_tdi,     vt[i].e_tdi);
      chk($sformatf("v%0d_rise", i), j_rise,    vt[i].e_rise);
      chk($sformatf("v%0d_fall", i), j_fall,    vt[i].e_fall);
      chk($sformatf("v%0d_oval", i), p_oval[3], vt[i].e_oval);
      chk($sformatf("v%0d_oe", i),   p_oe[3],   vt[i].e_oe);
      chk($sformatf("v%0d_tms2", i), k_tms,     vt[i].e_tms2);
    end

    // TRST_n pad activity
    trstn = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
`ifdef UX607_JTAGPORT_TRST_EN
      chk("trstn_low", j_trst, (k >= 5) ? 1'b1 : 1'b0);
`else
      chk("trstn_ignored", j_trst, 1'b0);
`endif
    end
    trstn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
`ifdef UX607_JTAGPORT_TRST_EN
      chk("trstn_high", j_trst, (k < 5) ? 1'b1 : 1'b0);
`else
      chk("trstn_ignored2", j_trst, 1'b0);
`endif
    end

    // Reset mid-operation with a TDI filter count in flight and oe_q=1
    chk("pre_rst_oe", p_oe[3], 1'b1);
    tdi = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", p_oe[3], 1'b0);
    chk("mid_rst_oval", p_oval[3], 1'b0);
    chk("mid_rst_trst", j_trst, 1'b1);
    chk("mid_rst_tms", j_tms, 1'b1);
    chk("mid_rst_tdi", j_tdi, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("post_tms", j_tms, (k < 5) ? 1'b1 : 1'b0);
      chk("post_tdi", j_tdi, (k < 5) ? 1'b1 : 1'b0);
      chk("post_trst", j_trst, trst_exp(k, trst_lat));
      chk("post_oe", p_oe[3], 1'b0);
      chk("post_no_rise", j_rise, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ux607_jtagpinport_sync.md
Name: ux607_jtagpinport_sync

Overview:
Parametrised JTAG pin conditioner between the JTAG GPIO pads and the debug module in the ux607 peripheral subsystem. Oversamples TCK/TMS/TDI/TRST_n on the system clock through a synchronizer chain and a stability (glitch) filter per input. Produces one-cycle TCK edge strobes. Launches TDO/TDO-enable from a register updated on the filtered TCK falling edge.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input; legal range >=2.
FILT_CYCLES, 3, consecutive stable samples needed before a filtered output changes; 1 = no filtering; legal range 1..15.
PULLUP_EN, 1, value driven on io_pins_{TCK,TMS,TDI,TRST_n}_o_pue.

Ports:
clock  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
io_pins_{TCK,TMS,TDI,TDO,TRST_n}_i_ival  in  1 each  pad input values; TDO ival unused.
io_pins_{TCK,TMS,TDI,TDO,TRST_n}_o_{oval,oe,ie,pue,ds}  out  1 each  pad controls.
io_jtag_TCK, io_jtag_TMS, io_jtag_TDI  out  1  filtered JTAG inputs.
io_jtag_TRST  out  1  filtered, inverted TRST_n; active-high.
io_jtag_TCK_rise, io_jtag_TCK_fall  out  1  one-cycle strobes on filtered TCK edges.
io_jtag_TDO, io_jtag_DRV_TDO  in  1  TDO data and TDO output enable from the TAP.

Behaviour:
- Pad controls are constant, except TDO.
  - TCK/TMS/TDI/TRST_n pads: oval=0, oe=0, ie=1, pue=PULLUP_EN, ds=0.
  - TDO pad: oval=tdo_q, oe=oe_q, ie=0, pue=0, ds=0.
- Synchronizer: SYNC_STAGES flops per input. Async reset values: TCK 0, TMS 1, TDI 1, TRST_n 0.
- Filter, per input, with sample s (last sync stage), state f (reset value = same as sync reset value) and counter c (4 bits, reset 0):
  - If s==f: c<=0.
  - Else if c+1==FILT_CYCLES: f<=s, c<=0.
  - Else: c<=c+1.
  - Any sample equal to f restarts the count, so a glitch shorter than FILT_CYCLES cycles is never passed.
- Latency: a pad change held steady appears on io_jtag_* exactly SYNC_STAGES+FILT_CYCLES clocks after the first sampling edge. Default is 5.
- Outputs: io_jtag_TCK=f_TCK, io_jtag_TMS=f_TMS, io_jtag_TDI=f_TDI, io_jtag_TRST=~f_TRST_n. io_jtag_TRST is therefore 1 out of reset until TRST_n is filtered high.
- Edge strobes: tck_q<=f_TCK, reset 0.
  - io_jtag_TCK_rise = f_TCK & ~tck_q.
  - io_jtag_TCK_fall = ~f_TCK & tck_q.
  - Each is exactly one cycle wide, and the two are mutually exclusive.
  - No strobe is produced by reset or reset release.
- TDO launch: in the cycle io_jtag_TCK_fall=1, tdo_q<=io_jtag_TDO and oe_q<=io_jtag_DRV_TDO. Otherwise both hold. Reset values are tdo_q=0, oe_q=0.
  - Pad change is visible the cycle after the fall strobe.
  - io_jtag_TDO changes outside fall strobes have no effect.
- Reset mid-operation: all flops return to reset values asynchronously. In-flight filter counts are discarded, the TDO pad is released (oe=0), and TRST asserts.
- TRST filtered high while TCK is toggling: independent channels, with no ordering imposed.

Optional Feature:
Macro: UX607_JTAGPORT_TRST_EN.
- Defined: TRST_n channel present as described above.
- Undefined:
  - TRST_n sync/filter is not instantiated; io_pins_TRST_n_i_ival is ignored.
  - TRST_n pad drives oval=0, oe=0, ie=0, pue=0, ds=0.
  - io_jtag_TRST comes from a 2-flop reset stretcher: async set to 1 by reset, then clears to 0 on the 2nd clock after reset deasserts.

Test Plan:
- Reset asserted, then released with pads idle (TCK=0, TMS=1, TDI=1, TRST_n=1), defaults -> during reset: io_jtag_TCK=0, TMS=1, TDI=1, TRST=1, TDO oe=0. After release: TRST falls to 0 exactly 5 clocks after the first sampling edge; no TCK strobes.
- TMS pad 1->0 held, defaults -> io_jtag_TMS falls exactly 5 clocks later. Repeat with SYNC_STAGES=3, FILT_CYCLES=1 -> 4 clocks.
- TCK pad pulses high for 2 clocks, then 0 (FILT_CYCLES=3) -> io_jtag_TCK stays 0, no rise strobe. A 3-clock pulse -> TCK high for 3 clocks, one rise strobe and one fall strobe.
- io_jtag_TDO=1 and DRV_TDO=1 applied while TCK is high, TCK pad then falls -> pad oval=1, oe=1 the cycle after the fall strobe. TDO toggled mid-low-phase -> oval unchanged.
- Reset asserted while a filter count is in progress and oe_q=1 -> TDO oe drops to 0 immediately (asynchronously); TRST=1; after release, a fresh 5-clock latency applies.
- Macro undefined -> TRST pad ie=0, pue=0; io_jtag_TRST=1 during reset and 0 exactly 2 clocks after release; TRST_n pad activity is ignored.
